// File: rtl/mealy_seq_detector_pkg.sv
// Shared constants and elaboration-time table builders for mealy_seq_detector.
// Tables are sized for the largest legal configuration and indexed sparsely.
package mealy_seq_pkg;

  localparam int unsigned SYM_W_MIN = 1;
  localparam int unsigned SYM_W_MAX = 4;
  localparam int unsigned DEPTH_MIN = 2;
  localparam int unsigned DEPTH_MAX = 16;

  typedef logic [DEPTH_MAX-1:0][4:0] fail_vec_t;
  typedef logic [DEPTH_MAX-1:0][(1 << SYM_W_MAX)-1:0][4:0] next_tbl_t;

  function automatic logic [3:0] sym_at(input logic [63:0] pat,
                                        input int unsigned i,
                                        input int unsigned sym_w);
    return 4'((pat >> (i * sym_w)) & ((64'd1 << sym_w) - 64'd1));
  endfunction

  // f[i]: longest proper prefix of P[0..i] that is also a suffix of it.
  function automatic fail_vec_t fail_fn(input logic [63:0] pat,
                                        input int unsigned depth,
                                        input int unsigned sym_w);
    fail_vec_t   f;
    int unsigned k;
    f = '0;
    k = 0;
    for (int unsigned i = 1; i < depth; i++) begin
      while (k > 0 && sym_at(pat, i, sym_w) != sym_at(pat, k, sym_w))
        k = 32'(f[4'(k - 1)]);
      if (sym_at(pat, i, sym_w) == sym_at(pat, k, sym_w))
        k = k + 1;
      f[4'(i)] = 5'(k);
    end
    return f;
  endfunction

  function automatic next_tbl_t next_fn(input logic [63:0] pat,
                                        input int unsigned depth,
                                        input int unsigned sym_w);
    next_tbl_t   t;
    fail_vec_t   f;
    int unsigned k;
    t = '0;
    f = fail_fn(pat, depth, sym_w);
    for (int unsigned s = 0; s < depth; s++) begin
      for (int unsigned sym = 0; sym < (32'd1 << sym_w); sym++) begin
        k = s;
        while (k > 0 && 4'(sym) != sym_at(pat, k, sym_w))
          k = 32'(f[4'(k - 1)]);
        t[4'(s)][4'(sym)] = (4'(sym) == sym_at(pat, k, sym_w)) ? 5'(k + 1) : 5'd0;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/mealy_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and active-low synchronous reset.
module mealy_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en && count != '1)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy sequence detector with KMP-style resume on overlap.
// Optional match counter and match_cnt port built when MEALY_SEQ_COUNT_EN is defined.
module mealy_seq_detector
  import mealy_seq_pkg::*;
#(
  parameter int unsigned              SYM_W   = 2,
  parameter int unsigned              DEPTH   = 4,
  parameter logic [DEPTH*SYM_W-1:0]   PATTERN = {2'b01, 2'b00, 2'b01, 2'b10},
  parameter bit                       OVERLAP = 1'b1,
  parameter int unsigned              CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         a,
  input  logic                     clear,
  output logic                     out,
  output logic [$clog2(DEPTH)-1:0] progress
`ifdef MEALY_SEQ_COUNT_EN
  ,
  output logic [CNT_W-1:0]         match_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

  if (SYM_W < SYM_W_MIN || SYM_W > SYM_W_MAX ||
      DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || CNT_W < 1) begin : g_bad_param
    $error("mealy_seq_detector: SYM_W, DEPTH or CNT_W out of legal range");
  end

  localparam logic [63:0]       PAT_EXT  = 64'(PATTERN);
  localparam fail_vec_t         FAIL     = fail_fn(PAT_EXT, DEPTH, SYM_W);
  localparam next_tbl_t         NEXT     = next_fn(PAT_EXT, DEPTH, SYM_W);
  localparam logic [SYM_W-1:0]  LAST_SYM = PATTERN[(DEPTH-1)*SYM_W +: SYM_W];
  localparam logic [PW-1:0]     LAST_ST  = PW'(DEPTH - 1);
  localparam logic [PW-1:0]     RESUME   = OVERLAP ? PW'(FAIL[4'(DEPTH - 1)]) : '0;

  logic [PW-1:0] state;
  logic [PW-1:0] state_next;

  // The full-match entry of NEXT is never used; the match branch overrides it.
  always_comb begin
    state_next = state;
    out        = 1'b0;
    if (!reset || clear) begin
      state_next = '0;
    end else if (in_valid) begin
      if (state == LAST_ST && a == LAST_SYM) begin
        out        = 1'b1;
        state_next = RESUME;
      end else begin
        state_next = PW'(NEXT[4'(state)][4'(a)]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= '0;
    else
      state <= state_next;
  end

  assign progress = state;

`ifdef MEALY_SEQ_COUNT_EN
  mealy_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (out),
    .clear (clear),
    .count (match_cnt)
  );
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench: a suffix/prefix history model predicts each cycle, a monitor compares.
// Four instances: default (CNT_W 8 and 2) and SYM_W=1/DEPTH=3 pattern 1,0,1 (overlap on/off).
module tb_mealy_seq_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, clr_a, vld_a;
  logic [1:0] sym_a;
  logic       rst_b, clr_b, vld_b;
  logic [0:0] sym_b;

  logic       out0, out1, out2, out3;
  logic [1:0] prog0, prog1, prog2, prog3;
`ifdef MEALY_SEQ_COUNT_EN
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;
`endif

  mealy_seq_detector #(.CNT_W(8)) u0 (
    .clk(clk), .reset(rst_a), .in_valid(vld_a), .a(sym_a), .clear(clr_a),
    .out(out0), .progress(prog0)
`ifdef MEALY_SEQ_COUNT_EN
    , .match_cnt(cnt0)
`endif
  );

  mealy_seq_detector #(.SYM_W(1), .DEPTH(3), .PATTERN(3'b101), .OVERLAP(1'b1)) u1 (
    .clk(clk), .reset(rst_b), .in_valid(vld_b), .a(sym_b), .clear(clr_b),
    .out(out1), .progress(prog1)
`ifdef MEALY_SEQ_COUNT_EN
    , .match_cnt(cnt1)
`endif
  );

  mealy_seq_detector #(.SYM_W(1), .DEPTH(3), .PATTERN(3'b101), .OVERLAP(1'b0)) u2 (
    .clk(clk), .reset(rst_b), .in_valid(vld_b), .a(sym_b), .clear(clr_b),
    .out(out2), .progress(prog2)
`ifdef MEALY_SEQ_COUNT_EN
    , .match_cnt(cnt2)
`endif
  );

  mealy_seq_detector #(.CNT_W(2)) u3 (
    .clk(clk), .reset(rst_a), .in_valid(vld_a), .a(sym_a), .clear(clr_a),
    .out(out3), .progress(prog3)
`ifdef MEALY_SEQ_COUNT_EN
    , .match_cnt(cnt3)
`endif
  );

  typedef struct packed {
    logic [3:0]      out;
    logic [3:0][7:0] prog;
    logic [3:0][7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: recent accepted symbols per instance (oldest first).
  int hist[4][16];
  int hlen[4];
  int cnt_m[4];
  int pat[4][4];
  int depth[4];
  bit ovl[4];
  int cmax[4];

  function automatic bit ends_with(int i, int len);
    if (hlen[i] < len) return 1'b0;
    for (int j = 0; j < len; j++)
      if (hist[i][hlen[i] - len + j] != pat[i][j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int prefix_len(int i);
    for (int len = depth[i] - 1; len >= 1; len--)
      if (ends_with(i, len)) return len;
    return 0;
  endfunction

  task automatic push_sym(int i, int s);
    if (hlen[i] == 16) begin
      for (int j = 0; j < 15; j++) hist[i][j] = hist[i][j + 1];
      hist[i][15] = s;
    end else begin
      hist[i][hlen[i]] = s;
      hlen[i]++;
    end
  endtask

  task automatic model(int i, bit r, bit c, bit v, int s,
                       output bit o, output int p, output int k);
    p = prefix_len(i);
    k = cnt_m[i];
    o = r && !c && v && ends_with(i, depth[i] - 1) && (s == pat[i][depth[i] - 1]);
    if (!r || c) begin
      hlen[i]  = 0;
      cnt_m[i] = 0;
    end else if (v) begin
      push_sym(i, s);
      if (o) begin
        if (cnt_m[i] < cmax[i]) cnt_m[i]++;
        if (!ovl[i]) hlen[i] = 0;
      end
    end
  endtask

  task automatic step(bit ra, bit ca, bit va, int sa, bit rb, bit cb, bit vb, int sb);
    exp_t e;
    bit   o;
    int   p, k;
    @(negedge clk);
    rst_a = ra; clr_a = ca; vld_a = va; sym_a = 2'(sa);
    rst_b = rb; clr_b = cb; vld_b = vb; sym_b = 1'(sb);
    e = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || i == 3) model(i, ra, ca, va, sa, o, p, k);
      else                  model(i, rb, cb, vb, sb, o, p, k);
      e.out[i]  = o;
      e.prog[i] = 8'(p);
      e.cnt[i]  = 8'(k);
    end
    sb_q.push_back(e);
  endtask

  task automatic sa_(bit r, bit c, bit v, int s);
    step(r, c, v, s, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic sb_(bit r, bit c, bit v, int s);
    step(1'b1, 1'b0, 1'b0, 0, r, c, v, s);
  endtask

  task automatic check(string nm, int act, int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: one scoreboard entry per driven cycle, sampled mid-low-phase.
  initial begin : monitor
    exp_t       e;
    logic [3:0] ao;
    int         ap[4];
`ifdef MEALY_SEQ_COUNT_EN
    int         ac[4];
`endif
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        ao = {out3, out2, out1, out0};
        ap = '{int'(prog0), int'(prog1), int'(prog2), int'(prog3)};
`ifdef MEALY_SEQ_COUNT_EN
        ac = '{int'(cnt0), int'(cnt1), int'(cnt2), int'(cnt3)};
`endif
        for (int i = 0; i < 4; i++) begin
          check($sformatf("u%0d.out", i), int'(ao[i]), int'(e.out[i]));
          check($sformatf("u%0d.progress", i), ap[i], int'(e.prog[i]));
`ifdef MEALY_SEQ_COUNT_EN
          check($sformatf("u%0d.match_cnt", i), ac[i], int'(e.cnt[i]));
`endif
        end
      end
    end
  end

  initial begin : driver
    int posa, posb;
    bit va, vb;
    int sa, sb;
    pat[0] = '{2, 1, 0, 1}; pat[3] = '{2, 1, 0, 1};
    pat[1] = '{1, 0, 1, 0}; pat[2] = '{1, 0, 1, 0};
    depth  = '{4, 3, 3, 4};
    ovl    = '{1'b1, 1'b1, 1'b0, 1'b1};
    cmax   = '{255, 255, 255, 3};
    hlen   = '{0, 0, 0, 0};
    cnt_m  = '{0, 0, 0, 0};

    rst_a = 1'b0; clr_a = 1'b0; vld_a = 1'b0; sym_a = '0;
    rst_b = 1'b0; clr_b = 1'b0; vld_b = 1'b0; sym_b = '0;
    repeat (2) @(negedge clk);

    // Single pattern 10,01,00,01
    sa_(1, 0, 1, 2); sa_(1, 0, 1, 1); sa_(1, 0, 1, 0); sa_(1, 0, 1, 1);
    sa_(1, 0, 0, 3); sa_(1, 0, 0, 0);
    // Bubbles between 2nd and 3rd symbols
    sa_(1, 0, 1, 2); sa_(1, 0, 1, 1); sa_(1, 0, 0, 0); sa_(1, 0, 0, 3);
    sa_(1, 0, 1, 0); sa_(1, 0, 1, 1); sa_(1, 0, 0, 0);
    // Reset mid-sequence discards the partial match
    sa_(1, 0, 1, 2); sa_(1, 0, 1, 1); sa_(1, 0, 1, 0); sa_(0, 0, 1, 1);
    sa_(1, 0, 1, 1); sa_(1, 0, 0, 0);
    // Clear coincident with the final symbol
    sa_(1, 0, 1, 2); sa_(1, 0, 1, 1); sa_(1, 0, 1, 0); sa_(1, 1, 1, 1);
    sa_(1, 0, 0, 0);
    // Five back-to-back patterns: small counter saturates
    for (int n = 0; n < 5; n++)
      for (int j = 0; j < 4; j++) sa_(1, 0, 1, pat[0][j]);
    sa_(1, 0, 0, 0); sa_(1, 0, 0, 0);
    // 1-bit pattern 1,0,1 with stream 1,0,1,0,1
    sb_(1, 0, 1, 1); sb_(1, 0, 1, 0); sb_(1, 0, 1, 1); sb_(1, 0, 1, 0); sb_(1, 0, 1, 1);
    sb_(1, 0, 0, 0); sb_(1, 1, 0, 0);

    // Randomised traffic, biased toward pattern symbols
    posa = 0; posb = 0;
    for (int n = 0; n < 3000; n++) begin
      va = ($urandom_range(0, 3) != 0);
      vb = ($urandom_range(0, 3) != 0);
      sa = ($urandom_range(0, 1) == 1) ? pat[0][posa] : int'($urandom_range(0, 3));
      sb = ($urandom_range(0, 1) == 1) ? pat[1][posb] : int'($urandom_range(0, 1));
      if (va) posa = (posa + 1) % 4;
      if (vb) posb = (posb + 1) % 3;
      step($urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0, va, sa,
           $urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0, vb, sb);
    end
    sa_(1, 0, 0, 0);

    for (int w = 0; w < 20 && sb_q.size() > 0; w++) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mealy_seq_detector.md
# mealy_seq_detector

Parametrised Mealy sequence detector for a symbol stream: compares each valid SYM_W-bit input symbol against a fixed DEPTH-symbol pattern and raises `out` combinationally in the same cycle as the last matching symbol. Successor to the fixed 2-bit, single-pattern Mealy machine. Adds configurable width and depth, a valid qualifier, selectable overlapping or non-overlapping detection, synchronous clear, and an optional match counter. Sits directly on a symbol bus between a stimulus source and downstream event logic.

## Interface
- SYM_W, 2: symbol width in bits; legal range 1..4.
- DEPTH, 4: pattern length in symbols; legal range 2..16.
- PATTERN, {2'b01,2'b00,2'b01,2'b10}: flat DEPTH*SYM_W vector; symbol 0 (first expected) in LSBs, so the default sequence is 10,01,00,01.
- OVERLAP, 1: 1 = after a match, resume from the longest proper prefix that is also a suffix; 0 = restart at state 0.
- CNT_W, 8: match counter width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  `a` carries a symbol this cycle.
- a  in  SYM_W  input symbol.
- clear  in  1  synchronous flush of state and counter.
- out  out  1  Mealy match pulse, combinational.
- progress  out  $clog2(DEPTH)  current matched-prefix length (registered state).
- match_cnt  out  CNT_W  saturating match count; present only with MEALY_SEQ_COUNT_EN.

## Operation
- State `s` = number of pattern symbols currently matched, 0..DEPTH-1. `progress` = `s`.
- Elaboration-time transition table `next[s][sym]`:
  - Failure function `f[i]` is the KMP longest proper prefix of P[0..i] that is also a suffix of it.
  - `next[s][sym]`: walk `k=s` down through `f[k-1]` while `sym != P[k]`. If `sym == P[k]`, result is `k+1`, otherwise 0.
- Match condition: `in_valid && s==DEPTH-1 && a==P[DEPTH-1] && !clear && reset`. This drives `out`=1.
- On a match, next state is `f[DEPTH-1]` if OVERLAP=1, otherwise 0.
- No match with `in_valid`=1: `s <= next[s][a]`.
- `in_valid`=0: `s` holds and `out`=0.
- `clear`=1: `s <= 0`, `out`=0, counter cleared. `clear` has priority over `in_valid`.
- reset low: `s <= 0`, `out`=0, counter cleared. Reset has priority over `clear`. Reset applied mid-sequence discards any partial match.
- Counter:
  - Increments on every clock edge where `out`=1.
  - Saturates at 2^CNT_W-1; never wraps.

## Timing
- `out` has zero latency: it is a combinational function of `a`, `in_valid`, `clear`, `reset` and the registered `s`.
- `s` and `match_cnt` update on the rising edge of `clk`. `match_cnt` reflects a match one cycle after the `out` pulse.
- Reset values: `s`=0, `progress`=0, `match_cnt`=0. `out`=0 while reset is low.
- Back-to-back matches:
  - OVERLAP=1: matches may occur every DEPTH-f[DEPTH-1] valid symbols.
  - OVERLAP=0: matches occur at most once every DEPTH valid symbols.
- Bubbles (`in_valid`=0) between symbols do not break a partial match.

## Configuration
- MEALY_SEQ_COUNT_EN defined: the `match_cnt` port and its CNT_W-bit saturating counter are built.
- MEALY_SEQ_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `mealy_seq_pkg` holds:
  - constant functions `fail_fn` and `next_fn`, which build the failure vector and the DEPTH x 2^SYM_W transition table from PATTERN;
  - parameter-range check constants.
- One sub-module, `mealy_sat_counter` (CNT_W, increment enable, sync clear, active-low sync reset), is instantiated under the macro.
- Top-level registers: state register plus combinational `out`.
- Elaboration fails if SYM_W or DEPTH is outside its legal range.

## Test plan
- Default parameters, stream 10,01,00,01 after reset release -> `out`=1 only during the 4th symbol; `progress` reads 0,1,2,3,0; `match_cnt`=1 one cycle later.
- Default parameters, stream 10,01,00,01 with `in_valid`=0 for two cycles between the 2nd and 3rd symbols -> `progress` holds at 2 through the bubbles; `out` pulses on the 4th valid symbol.
- SYM_W=1, DEPTH=3, PATTERN 1,0,1, stream 1,0,1,0,1:
  - OVERLAP=1 -> `out` on the 3rd and 5th symbols;
  - OVERLAP=0 -> `out` on the 3rd symbol only.
- Default parameters, reset driven low after 10,01,00 then released, stream 01 -> no match; `progress`=0.
- `clear` asserted in the same cycle as the final 01 of a full pattern -> `out`=0, `progress`=0, `match_cnt`=0.
- CNT_W=2 with MEALY_SEQ_COUNT_EN defined, 5 complete patterns -> `match_cnt` sequence 1,2,3,3,3 (saturates at 3, no wrap).
